// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a byte FIFO and its drain-side consumer.
//
// Read handshake: the FIFO presents its head word on read_data whenever
// fifo_empty is low. The consumer pops that word by raising trigger_read
// for exactly one clock cycle. trigger_read is only ever raised after a
// cycle in which fifo_empty was sampled low, so the FIFO never sees a pop
// while it is empty. The FIFO advances its head on the rising edge that
// closes the trigger_read cycle.
interface fifo_uart_tx_if #(
  parameter int WSIZE = 8
);

  logic             fifo_empty;
  logic [WSIZE-1:0] read_data;
  logic             trigger_read;

  // Consumer side: samples the flag and the data, drives the pop strobe.
  modport master (
    input  fifo_empty,
    input  read_data,
    output trigger_read
  );

  // FIFO side: presents the flag and the head word, receives the pop strobe.
  modport slave (
    output fifo_empty,
    output read_data,
    input  trigger_read
  );

endinterface : fifo_uart_tx_if

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter (8N1 framing, WSIZE data bits, LSB first).
//
// Whenever enabled and the FIFO holds a word, the block pops one word,
// then sends a start bit, WSIZE data bits and one stop bit, each held for
// CLKS_PER_BIT clocks. There is one idle cycle and one fetch cycle between
// frames. tx and trigger_read come straight from flops, so their next
// values are worked out from the next state.
module fifo_uart_tx #(
  parameter int WSIZE        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  fifo_uart_tx_if.master    fifo,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        o_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(WSIZE) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WSIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [BIT_W-1:0]  r_bit;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [WSIZE-1:0]  r_shreg;
  logic [WSIZE-1:0]  w_shreg_nxt;

  logic              r_tx;
  logic              r_trigger;
  logic              w_tx_nxt;
  logic              w_trigger_nxt;
  logic              w_busy;
  logic              w_frame_done;

  logic              w_bit_end;
  logic              w_last_bit;
  logic              w_start_req;

  // The current serial bit ends on the last baud tick.
  assign w_bit_end   = (r_baud == BAUD_LAST);
  // The last data bit is the one with index WSIZE-1.
  assign w_last_bit  = (r_bit == BIT_LAST);
  // A new frame may only begin when enabled and a word is waiting.
  assign w_start_req = enable && !fifo.fifo_empty;

  // State register. Reset abandons any frame in progress at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. fifo_empty and enable are looked at only in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_req) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next_state = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && w_last_bit) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Next values for the baud counter, bit counter and shift register.
  always_comb begin
    w_baud_nxt  = '0;
    w_bit_nxt   = '0;
    w_shreg_nxt = r_shreg;

    // The baud counter runs only while a bit is on the line.
    if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
      if (w_bit_end) begin
        w_baud_nxt = '0;
      end else begin
        w_baud_nxt = r_baud + 1'b1;
      end
    end

    // The bit counter advances at the end of each data bit and clears when
    // leaving DATA, so every frame starts counting from zero.
    if (r_state == S_DATA) begin
      if (w_bit_end) begin
        w_bit_nxt = w_last_bit ? '0 : (r_bit + 1'b1);
      end else begin
        w_bit_nxt = r_bit;
      end
    end

    // The head word is captured on the edge that enters FETCH, before the
    // pop takes effect. Each finished data bit is shifted out to the right.
    if ((r_state == S_IDLE) && w_start_req) begin
      w_shreg_nxt = fifo.read_data;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      w_shreg_nxt = r_shreg >> 1;
    end
  end

  // Output decode. tx and trigger_read are taken from the next state so
  // that the flops hold them in step with the state register.
  always_comb begin
    w_trigger_nxt = (w_next_state == S_FETCH);
    case (w_next_state)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy       = (r_state != S_IDLE);
    w_frame_done = (r_state == S_STOP) && w_bit_end;
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud    <= '0;
      r_bit     <= '0;
      r_shreg   <= '0;
      r_tx      <= 1'b1;
      r_trigger <= 1'b0;
    end else begin
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_shreg   <= w_shreg_nxt;
      r_tx      <= w_tx_nxt;
      r_trigger <= w_trigger_nxt;
    end
  end

  assign fifo.trigger_read = r_trigger;
  assign tx                = r_tx;
  assign busy              = w_busy;
  assign frame_done        = w_frame_done;
  assign o_state           = r_state;

endmodule : fifo_uart_tx

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4 and WSIZE=8.
// The bench holds a queue-based FIFO feeding the DUT and a scoreboard
// (exp_q) of the words the FIFO accepted. Expected frames come from the
// 8N1 rule: frame bit k is held for CPB cycles; bit 0 is the start bit (0),
// bits 1..8 are the data bits LSB first, and bit 9 is the stop bit (1).
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int W     = 8;
  localparam int FLEN  = (W + 2) * CPB;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] st;

  always #5 clk = ~clk;

  fifo_uart_tx_if #(.WSIZE(W)) fif ();

  fifo_uart_tx #(
    .WSIZE       (W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .enable    (enable),
    .fifo      (fif.master),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .o_state   (st)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FIFO model and scoreboard feed ----------------
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           pop_cnt = 0;
  int           underflow_cnt = 0;

  always @(posedge clk) begin
    if (fif.trigger_read === 1'b1) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo_q.size() == 0) underflow_cnt <= underflow_cnt + 1;
      else void'(fifo_q.pop_front());
    end
    if (wr_en === 1'b1 && fifo_q.size() < DEPTH) begin
      fifo_q.push_back(wr_data);
      exp_q.push_back(wr_data);
    end
    fif.fifo_empty <= (fifo_q.size() == 0);
    fif.read_data  <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fifo_write(input logic [W-1:0] w);
    @(negedge clk);
    while (fifo_q.size() >= DEPTH) @(negedge clk);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Waits for a pop, takes the expected word from the scoreboard and checks
  // the whole frame cycle by cycle. start_cyc is the first start-bit cycle.
  task automatic run_frame(input logic use_tab, input logic [9:0] tab_frame,
                           output int start_cyc);
    int           waited;
    logic         got;
    logic [W-1:0] w;
    logic [9:0]   fr;
    waited    = 0;
    got       = 1'b0;
    start_cyc = -1;
    while (!got && waited < 400) begin
      @(negedge clk);
      if (fif.trigger_read === 1'b1) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      chk("trigger_timeout", 32'd0, 32'd1);
      return;
    end
    chk("fetch_tx_idle", tx, 1);
    chk("fetch_busy", busy, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_underrun", 32'd0, 32'd1);
      return;
    end
    w  = exp_q.pop_front();
    fr = use_tab ? tab_frame : {1'b1, w, 1'b0};
    @(negedge clk);
    start_cyc = cyc;
    for (int k = 0; k < FLEN; k++) begin
      if (k > 0) @(negedge clk);
      chk("tx_bit", tx, fr[k / CPB]);
      chk("frame_done", frame_done, (k == FLEN - 1));
      chk("pop_single", fif.trigger_read, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] word;
    logic [9:0]   frame;   // line bits in time order, bit 0 first
  } vec_t;

  vec_t tab[6];

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int bad;
    int s;
    int prev;
    int got;
    int waited;

    tab[0] = '{8'hA5, 10'b1_10100101_0};
    tab[1] = '{8'h00, 10'b1_00000000_0};
    tab[2] = '{8'hFF, 10'b1_11111111_0};
    tab[3] = '{8'h3C, 10'b1_00111100_0};
    tab[4] = '{8'h01, 10'b1_00000001_0};
    tab[5] = '{8'h80, 10'b1_10000000_0};

    rst     = 1'b1;
    enable  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset asserted mid-cycle while idle with an empty FIFO.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_trigger", fif.trigger_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_state", st, 0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
    bad    = 0;
    p0     = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fif.trigger_read !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("empty_idle_quiet", bad, 0);
    chk("empty_idle_pops", pop_cnt - p0, 0);

    // Single frames from the vector table.
    for (int i = 0; i < 6; i++) begin
      p0 = pop_cnt;
      fork
        fifo_write(tab[i].word);
        run_frame(1'b1, tab[i].frame, s);
      join
      repeat (4) @(negedge clk);
      chk("single_frame_pops", pop_cnt - p0, 1);
      chk("single_frame_idle", busy, 0);
    end

    // Fill the FIFO to full while disabled, then drain back to back.
    enable = 1'b0;
    p0     = pop_cnt;
    for (int i = 0; i < 8; i++) fifo_write(W'(i));
    chk("fill_full", fifo_q.size(), DEPTH);
    chk("no_pop_disabled", pop_cnt - p0, 0);
    @(negedge clk);
    enable = 1'b1;
    prev   = -1;
    for (int i = 0; i < 8; i++) begin
      run_frame(1'b0, 10'd0, s);
      if (i > 0) chk("b2b_spacing", s - prev, FLEN + 2);
      prev = s;
    end
    chk("drained_empty", fif.fifo_empty, 1);
    repeat (60) @(negedge clk);
    chk("drain_pops", pop_cnt - p0, 8);

    // Enable dropped during the data bits of the first of three frames.
    enable = 1'b0;
    fifo_write(8'h11);
    fifo_write(8'h22);
    fifo_write(8'h33);
    p0 = pop_cnt;
    fork
      run_frame(1'b0, 10'd0, s);
      begin
        @(negedge clk);
        enable = 1'b1;
        repeat (15) @(negedge clk);
        enable = 1'b0;
      end
    join
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fif.trigger_read !== 1'b0) bad++;
    end
    chk("gated_quiet", bad, 0);
    chk("gated_pops", pop_cnt - p0, 1);
    enable = 1'b1;
    run_frame(1'b0, 10'd0, s);
    run_frame(1'b0, 10'd0, s);

    // Reset during data bit 3 of a 0x3C frame; the next word follows cleanly.
    enable = 1'b0;
    fifo_write(8'h3C);
    fifo_write(8'h5A);
    @(negedge clk);
    enable = 1'b1;
    got    = 0;
    waited = 0;
    while (got == 0 && waited < 50) begin
      @(negedge clk);
      if (fif.trigger_read === 1'b1) got = 1;
      else waited++;
    end
    chk("mid_reset_pop_seen", got, 1);
    repeat (CPB + 3 * CPB + 2) @(negedge clk);
    chk("mid_reset_in_frame", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_reset_tx", tx, 1);
    chk("mid_reset_trigger", fif.trigger_read, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_state", st, 0);
    void'(exp_q.pop_front());   // the popped 0x3C is lost by design
    p0 = pop_cnt;
    repeat (5) @(negedge clk);
    chk("pops_during_reset", pop_cnt - p0, 0);
    rst = 1'b0;
    run_frame(1'b0, 10'd0, s);

    // Producer writes 15..18 and then random words while the block drains.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          fifo_write((i < 4) ? W'(15 + i) : W'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 50)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 20; i++) run_frame(1'b0, 10'd0, s);
      end
    join

    repeat (20) @(negedge clk);
    chk("no_underflow", underflow_cnt, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_idle_tx", tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fifo_uart_tx
